// File: rtl/poly_osc_engine.sv
// Harmonic oscillator bank: VOICES phase accumulators share one sine LUT.
// Each sample period it sums the enabled voices and passes one word to the DAC SPI block.
module poly_osc_engine #(
  parameter int          VOICES          = 2,
  parameter int          PHASE_MOD       = 44000,
  parameter int          PHASE_W         = 16,
  parameter int          SAMPLE_INTERVAL = 1910,
  parameter int          LUT_ADDR_W      = 11,
  parameter int          LUT_SHIFT       = 5,
  parameter int          LUT_DATA_W      = 16,
  parameter int          LUT_LATENCY     = 2,
  parameter logic [7:0]  DAC_CMD         = 8'h31
) (
  input  logic                    clock,
  input  logic                    rstn,
  input  logic [PHASE_W-1:0]      frequency,
  input  logic [VOICES-1:0]       voice_enable,
  output logic [LUT_ADDR_W-1:0]   lut_addr,
  input  logic [LUT_DATA_W-1:0]   lut_value,
  input  logic                    dac_busy,
  output logic [LUT_DATA_W+7:0]   dac_word,
  output logic                    dac_send,
  output logic [LUT_DATA_W-1:0]   sample_out,
  output logic                    overrun,
  input  logic                    overrun_clr
);

  localparam int SUM_SH = $clog2(VOICES);
  localparam int SUM_W  = LUT_DATA_W + SUM_SH;
  localparam int K_W    = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam int TMR_W  = $clog2(SAMPLE_INTERVAL);
  localparam int WAIT_W = $clog2(LUT_LATENCY + 1);
  localparam logic [PHASE_W:0]   MOD_X  = (PHASE_W+1)'(PHASE_MOD);
  localparam logic [PHASE_W-1:0] MOD_M1 = PHASE_W'(PHASE_MOD - 1);

  if (VOICES < 1 || VOICES > 8) begin : g_bad_voices
    $error("poly_osc_engine: VOICES must be in 1..8");
  end
  if (VOICES * (LUT_LATENCY + 2) + 3 >= SAMPLE_INTERVAL) begin : g_bad_timing
    $error("poly_osc_engine: frame does not fit in SAMPLE_INTERVAL");
  end

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WAIT, S_ACC, S_OUT, S_PEND} state_t;

  // Both operands are below PHASE_MOD, so a single conditional subtraction wraps the sum.
  function automatic logic [PHASE_W-1:0] mod_add(input logic [PHASE_W-1:0] a,
                                                 input logic [PHASE_W-1:0] b);
    logic [PHASE_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= MOD_X) s = s - MOD_X;
    return s[PHASE_W-1:0];
  endfunction

  function automatic logic [PHASE_W-1:0] clamp_freq(input logic [PHASE_W-1:0] f);
    return ({1'b0, f} >= MOD_X) ? MOD_M1 : f;
  endfunction

  state_t                r_state, w_state_nxt;
  logic [TMR_W-1:0]      r_timer;
  logic [WAIT_W-1:0]     r_wait;
  logic [K_W-1:0]        r_k;
  logic [PHASE_W-1:0]    r_phase [VOICES];
  logic [PHASE_W-1:0]    r_freq;
  logic [PHASE_W-1:0]    r_inc;
  logic [SUM_W-1:0]      r_acc;
  logic [LUT_ADDR_W-1:0] r_lut_addr;
  logic [LUT_DATA_W+7:0] r_dac_word;
  logic                  r_send;
  logic [LUT_DATA_W-1:0] r_sample;
  logic                  r_overrun;

  logic                  w_tick;
  logic                  w_last;
  logic                  w_send;
  logic                  w_ovr_set;
  logic [LUT_DATA_W-1:0] w_sample;

  assign w_tick   = (r_timer == '0);
  assign w_last   = (r_k == K_W'(VOICES - 1));
  assign w_sample = LUT_DATA_W'(r_acc >> SUM_SH);

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // A tick always starts a new frame; a sample still pending at that point is dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_send      = 1'b0;
    w_ovr_set   = 1'b0;
    if (w_tick) begin
      w_state_nxt = S_ADDR;
      w_ovr_set   = (r_state == S_PEND);
    end else begin
      case (r_state)
        S_IDLE: w_state_nxt = S_IDLE;
        S_ADDR: w_state_nxt = S_WAIT;
        S_WAIT: if (r_wait == WAIT_W'(LUT_LATENCY - 1)) w_state_nxt = S_ACC;
        S_ACC:  w_state_nxt = w_last ? S_OUT : S_ADDR;
        S_OUT, S_PEND: begin
          if (dac_busy) begin
            w_state_nxt = S_PEND;
          end else begin
            w_state_nxt = S_IDLE;
            w_send      = 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_timer    <= '0;
      r_wait     <= '0;
      r_k        <= '0;
      r_freq     <= '0;
      r_inc      <= '0;
      r_acc      <= '0;
      r_lut_addr <= '0;
      r_dac_word <= '0;
      r_send     <= 1'b0;
      r_sample   <= '0;
      r_overrun  <= 1'b0;
      for (int i = 0; i < VOICES; i++) r_phase[i] <= '0;
    end else begin
      r_timer <= (r_timer == TMR_W'(SAMPLE_INTERVAL - 1)) ? '0 : r_timer + TMR_W'(1);
      r_send  <= w_send;
      // The accumulator is frozen after OUT, so w_sample is still valid while pending.
      if (w_send) r_dac_word <= {DAC_CMD, w_sample};
      if (w_ovr_set)        r_overrun <= 1'b1;
      else if (overrun_clr) r_overrun <= 1'b0;
      if (w_tick) begin
        r_freq <= clamp_freq(frequency);
        r_inc  <= clamp_freq(frequency);
        r_acc  <= '0;
        r_k    <= '0;
      end else begin
        case (r_state)
          S_ADDR: begin
            r_lut_addr   <= LUT_ADDR_W'(r_phase[r_k] >> LUT_SHIFT);
            r_phase[r_k] <= mod_add(r_phase[r_k], r_inc);
            r_wait       <= '0;
          end
          S_WAIT: r_wait <= r_wait + WAIT_W'(1);
          S_ACC: begin
            r_acc <= r_acc + (voice_enable[r_k] ? SUM_W'(lut_value) : '0);
            r_inc <= mod_add(r_inc, r_freq);
            if (!w_last) r_k <= r_k + K_W'(1);
          end
          S_OUT:   r_sample <= w_sample;
          default: ;
        endcase
      end
    end
  end

  assign lut_addr   = r_lut_addr;
  assign dac_word   = r_dac_word;
  assign dac_send   = r_send;
  assign sample_out = r_sample;
  assign overrun    = r_overrun;

endmodule
